// File: rtl/sequential_divider.sv
// Signed 32-step restoring divider: one quotient bit per clock, sign fix-up in a final cycle.
// Truncates toward zero; the remainder takes the sign of the dividend.
//
// state | meaning
// IDLE  | waiting for start; operands latched and magnitudes formed on accept
// CALC  | one restoring shift/subtract step per clock (skipped when divisor is 0)
// FIX   | apply signs, write results, strobe enOut on the following cycle
module sequential_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             enOut,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             en_q, en_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH+1:0] trial;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            a_q      <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            quot_q   <= '0;
            remo_q   <= '0;
            en_q     <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            quot_q   <= quot_d;
            remo_q   <= remo_d;
            en_q     <= en_d;
            dbz_q    <= dbz_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        quot_d   = quot_q;
        remo_d   = remo_q;
        en_d     = 1'b0;
        dbz_d    = dbz_q;
        // Shift carries the top dividend bit into the partial remainder; one
        // extra bit keeps the trial sign visible for any 32-bit magnitude.
        rem_sh   = {rem_q, dvd_q[WIDTH-1]};
        trial    = rem_sh - {2'b00, dvs_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = in1;
                    sign_a_d = in1[WIDTH-1];
                    sign_b_d = in2[WIDTH-1];
                    dvd_d    = in1[WIDTH-1] ? -in1 : in1;
                    dvs_d    = in2[WIDTH-1] ? -in2 : in2;
                    rem_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (dvs_q == '0) begin
                    state_d = FIX;
                end else begin
                    if (!trial[WIDTH+1]) begin
                        rem_d = trial[WIDTH:0];
                        dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[WIDTH:0];
                        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'(WIDTH - 1)) state_d = FIX;
                end
            end
            FIX: begin
                en_d    = 1'b1;
                state_d = IDLE;
                if (dvs_q == '0) begin
                    quot_d = '1;
                    remo_d = a_q;
                    dbz_d  = 1'b1;
                end else begin
                    quot_d = (sign_a_q ^ sign_b_q) ? -dvd_q : dvd_q;
                    remo_d = sign_a_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                    dbz_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign quotient    = quot_q;
    assign remainder   = remo_q;
    assign enOut       = en_q;
    assign div_by_zero = dbz_q;

endmodule
